fma_unpack: RTL and testbench

- Operand front end of the fma16 datapath. It is the inverse of the final round/pack stage.
- Accepts three IEEE half-precision operands (x, y, z) over a valid/ready handshake.
- Classifies each operand and splits it into sign, unbiased exponent and mantissa with an explicit leading 1. Subnormal mantissas are normalized iteratively, one left shift per cycle.
- Presents the unpacked operands to the multiplier/adder stage over a second valid/ready handshake.

---
 rtl/fma16_pkg.sv | 65 ++++++
 rtl/fma_unpack_lane.sv | 118 +++++++++++
 rtl/fma_unpack.sv | 133 +++++++++++++
 tb/tb_fma_unpack.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fma16_pkg
//  Purpose  : Shared constants, types and helpers for the fma16 datapath.
//             Half-precision field widths, exponent bias, the unpacked
//             operand record and the unpack FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package fma16_pkg;

  localparam int NF           = 10;  // fraction bits
  localparam int NE           = 5;   // exponent field bits
  localparam int BIAS         = 15;
  localparam int EMAX_SPECIAL = 16;  // exponent reported for inf/NaN

  // Internal signed exponent width: covers -24..16 with margin.
  localparam int EXPI_W = 7;

  typedef struct packed {
    logic                     sign;
    logic signed [EXPI_W-1:0] exp;
    logic [NF:0]              mant;
    logic                     zero;
    logic                     inf;
    logic                     nan;
    logic                     snan;
    logic                     sub;
  } unpacked_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    HOLD = 2'd2
  } unpack_state_t;

  // Leading-zero count of an 11-bit mantissa (0..11).
  function automatic logic [3:0] lzc11(input logic [NF:0] v);
    logic [3:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = NF; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  function automatic logic op_is_zero(input logic [15:0] op);
    return (op[14:0] == 15'd0);
  endfunction

  function automatic logic op_is_inf(input logic [15:0] op);
    return (op[14:10] == 5'h1f) && (op[9:0] == 10'd0);
  endfunction

  // Signalling NaN: all-ones exponent, quiet bit clear, payload non-zero.
  function automatic logic op_is_snan(input logic [15:0] op);
    return (op[14:10] == 5'h1f) && !op[9] && (op[8:0] != 9'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fma_unpack_lane.sv
`default_nettype none
// ============================================================================
//  Module   : fma_unpack_lane
//  Purpose  : One operand lane: decodes a half-precision value at load,
//             holds it in a register and, while step is high, normalizes a
//             subnormal mantissa one bit per cycle.
//  Config   : FMA_UNPACK_FASTNORM_EN - normalize subnormals fully at load
//             (leading-zero count + barrel shift) instead of iteratively.
//  Ports    : clk, reset (async, active-high)
//             load      - capture decode of op
//             step      - normalization cycle (NORM state)
//             op        - 16-bit half-precision operand
//             need_norm - decoded op still requires shifting after load
//             done      - mantissa is normalized once this cycle's step lands
//             s/e/m     - sign, signed unbiased exponent, mantissa
//             zero/inf/nan/snan/sub - class flags
//  Revision : 1.0  initial release
// ============================================================================
module fma_unpack_lane
  import fma16_pkg::*;
#(
  parameter int EXPW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [15:0]     op,
  output logic            need_norm,
  output logic            done,
  output logic            s,
  output logic [EXPW-1:0] e,
  output logic [NF:0]     m,
  output logic            zero,
  output logic            inf,
  output logic            nan,
  output logic            snan,
  output logic            sub
);

  logic [NE-1:0] w_efld;
  logic [NF-1:0] w_frac;
  unpacked_t     w_dec;
  unpacked_t     r_q;
  logic          w_shift;
`ifdef FMA_UNPACK_FASTNORM_EN
  logic [3:0]    w_lz;
`endif

  assign w_efld = op[14:10];
  assign w_frac = op[9:0];

  always_comb begin
    w_dec      = '0;
    w_dec.sign = op[15];
`ifdef FMA_UNPACK_FASTNORM_EN
    w_lz       = '0;
`endif
    if (w_efld == '0) begin
      if (w_frac == '0) begin
        w_dec.zero = 1'b1;
      end else begin
        w_dec.sub  = 1'b1;
        w_dec.exp  = EXPI_W'(1 - BIAS);
        w_dec.mant = {1'b0, w_frac};
`ifdef FMA_UNPACK_FASTNORM_EN
        w_lz       = lzc11({1'b0, w_frac});
        w_dec.mant = {1'b0, w_frac} << w_lz;
        w_dec.exp  = EXPI_W'(1 - BIAS) - EXPI_W'(w_lz);
`endif
      end
    end else if (w_efld == '1) begin
      w_dec.exp  = EXPI_W'(EMAX_SPECIAL);
      w_dec.mant = {1'b1, w_frac};
      w_dec.inf  = (w_frac == '0);
      w_dec.nan  = (w_frac != '0);
      w_dec.snan = (w_frac != '0) & ~w_frac[NF-1];
    end else begin
      w_dec.exp  = EXPI_W'({2'b00, w_efld}) - EXPI_W'(BIAS);
      w_dec.mant = {1'b1, w_frac};
    end
  end

  // Only subnormal lanes without a leading one keep shifting.
  assign w_shift   = r_q.sub & ~r_q.mant[NF];
  assign need_norm = w_dec.sub & ~w_dec.mant[NF];
  // After this cycle's shift the leading bit will be the current bit NF-1.
  assign done      = ~w_shift | r_q.mant[NF-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_dec;
    end else if (step && w_shift) begin
      r_q.mant <= {r_q.mant[NF-1:0], 1'b0};
      r_q.exp  <= r_q.exp - EXPI_W'(1);
    end
  end

  generate
    if (EXPW > EXPI_W) begin : g_sext
      assign e = {{(EXPW-EXPI_W){r_q.exp[EXPI_W-1]}}, r_q.exp};
    end else begin : g_trunc
      assign e = r_q.exp[EXPW-1:0];
    end
  endgenerate

  assign s    = r_q.sign;
  assign m    = r_q.mant;
  assign zero = r_q.zero;
  assign inf  = r_q.inf;
  assign nan  = r_q.nan;
  assign snan = r_q.snan;
  assign sub  = r_q.sub;

endmodule
`default_nettype wire

// File: rtl/fma_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : fma_unpack
//  Purpose  : fma16 operand front end. Accepts x/y/z over valid/ready,
//             splits each into sign / unbiased exponent / explicit-one
//             mantissa with class flags, normalizes subnormals and offers
//             the result downstream over a second valid/ready handshake.
//  Config   : FMA_UNPACK_FASTNORM_EN - single-cycle subnormal normalization
//             (NORM state never entered).
//  Ports    : clk, reset (async, active-high)
//             in_valid/in_ready, x, y, z          - operand handshake
//             out_valid/out_ready                 - result handshake
//             xs..zs, xe..ze, xm..zm              - unpacked fields
//             *zero, *inf, *nan, *snan, *sub      - class flags
//             invalid - sNaN on any input, or inf*0 on x*y
//  Revision : 1.0  initial release
// ============================================================================
module fma_unpack
  import fma16_pkg::*;
#(
  parameter int EXPW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     x,
  input  logic [15:0]     y,
  input  logic [15:0]     z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            xs,
  output logic            ys,
  output logic            zs,
  output logic [EXPW-1:0] xe,
  output logic [EXPW-1:0] ye,
  output logic [EXPW-1:0] ze,
  output logic [NF:0]     xm,
  output logic [NF:0]     ym,
  output logic [NF:0]     zm,
  output logic            xzero,
  output logic            yzero,
  output logic            zzero,
  output logic            xinf,
  output logic            yinf,
  output logic            zinf,
  output logic            xnan,
  output logic            ynan,
  output logic            znan,
  output logic            xsnan,
  output logic            ysnan,
  output logic            zsnan,
  output logic            xsub,
  output logic            ysub,
  output logic            zsub,
  output logic            invalid
);

  unpack_state_t r_state, w_next;
  logic w_accept, w_step, w_need, w_all_done;
  logic w_x_need, w_y_need, w_z_need;
  logic w_x_done, w_y_done, w_z_done;
  logic r_invalid;

  assign w_accept   = in_valid & in_ready;
  assign w_step     = (r_state == NORM);
  assign w_need     = w_x_need | w_y_need | w_z_need;
  assign w_all_done = w_x_done & w_y_done & w_z_done;

  fma_unpack_lane #(.EXPW(EXPW)) u_lane_x (
    .clk(clk), .reset(reset), .load(w_accept), .step(w_step), .op(x),
    .need_norm(w_x_need), .done(w_x_done),
    .s(xs), .e(xe), .m(xm),
    .zero(xzero), .inf(xinf), .nan(xnan), .snan(xsnan), .sub(xsub)
  );

  fma_unpack_lane #(.EXPW(EXPW)) u_lane_y (
    .clk(clk), .reset(reset), .load(w_accept), .step(w_step), .op(y),
    .need_norm(w_y_need), .done(w_y_done),
    .s(ys), .e(ye), .m(ym),
    .zero(yzero), .inf(yinf), .nan(ynan), .snan(ysnan), .sub(ysub)
  );

  fma_unpack_lane #(.EXPW(EXPW)) u_lane_z (
    .clk(clk), .reset(reset), .load(w_accept), .step(w_step), .op(z),
    .need_norm(w_z_need), .done(w_z_done),
    .s(zs), .e(ze), .m(zm),
    .zero(zzero), .inf(zinf), .nan(znan), .snan(zsnan), .sub(zsub)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_invalid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_invalid <= op_is_snan(x) | op_is_snan(y) | op_is_snan(z)
                   | (op_is_inf(x) & op_is_zero(y))
                   | (op_is_inf(y) & op_is_zero(x));
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_need ? NORM : HOLD;
      end
      NORM: begin
        if (w_all_done) w_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        // Result consumed and new operands taken on the same edge.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_next = w_need ? NORM : HOLD;
          else          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign invalid = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_fma_unpack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fma_unpack
//  Purpose  : Directed self-checking bench for fma_unpack.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fma_unpack;

  localparam int EXPW = 7;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     x, y, z;
  logic            out_valid;
  logic            out_ready;
  logic            xs, ys, zs;
  logic [EXPW-1:0] xe, ye, ze;
  logic [10:0]     xm, ym, zm;
  logic            xzero, yzero, zzero, xinf, yinf, zinf;
  logic            xnan, ynan, znan, xsnan, ysnan, zsnan;
  logic            xsub, ysub, zsub, invalid;

  int checks = 0;
  int errors = 0;

  fma_unpack #(.EXPW(EXPW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z),
    .out_valid(out_valid), .out_ready(out_ready),
    .xs(xs), .ys(ys), .zs(zs),
    .xe(xe), .ye(ye), .ze(ze),
    .xm(xm), .ym(ym), .zm(zm),
    .xzero(xzero), .yzero(yzero), .zzero(zzero),
    .xinf(xinf), .yinf(yinf), .zinf(zinf),
    .xnan(xnan), .ynan(ynan), .znan(znan),
    .xsnan(xsnan), .ysnan(ysnan), .zsnan(zsnan),
    .xsub(xsub), .ysub(ysub), .zsub(zsub),
    .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected exponent as an EXPW-bit two's-complement pattern.
  function automatic logic [31:0] ev(input int v);
    logic [EXPW-1:0] t;
    t = v[EXPW-1:0];
    return 32'(t);
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x = '0; y = '0; z = '0;
    tick; tick;
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_xm",        32'(xm),        32'd0);
    chk("rst_xe",        32'(xe),        ev(0));
    chk("rst_invalid",   32'(invalid),   32'd0);

    // Case 1: normal operands and a zero, 1-cycle latency
    x = 16'h3C00; y = 16'h4000; z = 16'h0000;
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("c1_out_valid", 32'(out_valid), 32'd1);
    chk("c1_xe",        32'(xe),        ev(0));
    chk("c1_xm",        32'(xm),        32'h400);
    chk("c1_ye",        32'(ye),        ev(1));
    chk("c1_ym",        32'(ym),        32'h400);
    chk("c1_zzero",     32'(zzero),     32'd1);
    chk("c1_ze",        32'(ze),        ev(0));
    chk("c1_zm",        32'(zm),        32'd0);
    chk("c1_xsub",      32'(xsub),      32'd0);
    chk("c1_invalid",   32'(invalid),   32'd0);
    tick;
    chk("c1_idle_valid", 32'(out_valid), 32'd0);
    chk("c1_idle_ready", 32'(in_ready),  32'd1);

    // Case 2: subnormals, 10 NORM cycles
    x = 16'h0001; y = 16'h3C00; z = 16'h0200;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("c2_norm_ready", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("c2_norm_valid_cyc%0d", i), 32'(out_valid), 32'd0);
      tick;
    end
    chk("c2_out_valid", 32'(out_valid), 32'd1);
    chk("c2_xe",        32'(xe),        ev(-24));
    chk("c2_xm",        32'(xm),        32'h400);
    chk("c2_xsub",      32'(xsub),      32'd1);
    chk("c2_ye",        32'(ye),        ev(0));
    chk("c2_ysub",      32'(ysub),      32'd0);
    chk("c2_ze",        32'(ze),        ev(-15));
    chk("c2_zm",        32'(zm),        32'h400);
    chk("c2_zsub",      32'(zsub),      32'd1);
    tick;

    // Case 3: quiet and signalling NaNs
    x = 16'h7E00; y = 16'h7C01; z = 16'h3C00;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("c3_out_valid", 32'(out_valid), 32'd1);
    chk("c3_xnan",      32'(xnan),      32'd1);
    chk("c3_xsnan",     32'(xsnan),     32'd0);
    chk("c3_xe",        32'(xe),        ev(16));
    chk("c3_xm",        32'(xm),        32'h600);
    chk("c3_ynan",      32'(ynan),      32'd1);
    chk("c3_ysnan",     32'(ysnan),     32'd1);
    chk("c3_ym",        32'(ym),        32'h401);
    chk("c3_znan",      32'(znan),      32'd0);
    chk("c3_invalid",   32'(invalid),   32'd1);
    tick;

    // Case 4: inf * -0
    x = 16'h7C00; y = 16'h8000; z = 16'h3C00;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("c4_xinf",    32'(xinf),    32'd1);
    chk("c4_xnan",    32'(xnan),    32'd0);
    chk("c4_xe",      32'(xe),      ev(16));
    chk("c4_xm",      32'(xm),      32'h400);
    chk("c4_ys",      32'(ys),      32'd1);
    chk("c4_yzero",   32'(yzero),   32'd1);
    chk("c4_invalid", 32'(invalid), 32'd1);
    tick;

    // Case 5: backpressure then back-to-back accept
    x = 16'h4200; y = 16'hC000; z = 16'h0400;
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    x = 16'h5640; y = 16'h3800; z = 16'hFC00;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("c5_hold_ready_%0d", i), 32'(in_ready),  32'd0);
      chk($sformatf("c5_hold_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("c5_hold_xm_%0d", i),    32'(xm),        32'h600);
      chk($sformatf("c5_hold_xe_%0d", i),    32'(xe),        ev(1));
      chk($sformatf("c5_hold_ys_%0d", i),    32'(ys),        32'd1);
      chk($sformatf("c5_hold_ze_%0d", i),    32'(ze),        ev(-14));
      tick;
    end
    out_ready = 1'b1;
    #1;
    chk("c5_ready_follow", 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    chk("c5_b_valid",   32'(out_valid), 32'd1);
    chk("c5_b_xe",      32'(xe),        ev(6));
    chk("c5_b_xm",      32'(xm),        32'h640);
    chk("c5_b_ye",      32'(ye),        ev(-1));
    chk("c5_b_ym",      32'(ym),        32'h400);
    chk("c5_b_zs",      32'(zs),        32'd1);
    chk("c5_b_zinf",    32'(zinf),      32'd1);
    chk("c5_b_invalid", 32'(invalid),   32'd0);
    tick;

    // Case 6: reset during the third NORM cycle
    x = 16'h0001; y = 16'h3C00; z = 16'h0200;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    reset = 1'b1;
    #1;
    chk("c6_rst_valid", 32'(out_valid), 32'd0);
    chk("c6_rst_ready", 32'(in_ready),  32'd1);
    chk("c6_rst_xm",    32'(xm),        32'd0);
    chk("c6_rst_xe",    32'(xe),        ev(0));
    chk("c6_rst_xsub",  32'(xsub),      32'd0);
    chk("c6_rst_zm",    32'(zm),        32'd0);
    #1;
    reset = 1'b0;
    x = 16'h3C00; y = 16'h3C00; z = 16'h3C00;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("c6_fresh_valid", 32'(out_valid), 32'd1);
    chk("c6_fresh_xe",    32'(xe),        ev(0));
    chk("c6_fresh_xm",    32'(xm),        32'h400);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
